// File: rtl/seg_hex_scanner.sv
// seg_hex_scanner: shows a 32-bit shadow word as eight hex digits on a
// multiplexed 7-segment display. There is optional leading-zero blanking.
// Every output comes from a flop.
//
// Ports:
//   clk     system clock, rising edge
//   reset   synchronous, active-high; takes priority over load and enable
//   data    word to display; nibble k drives digit k (digit 0 is rightmost)
//   load    captures data into the shadow register on a rising edge
//   enable  0 turns the display dark and holds the scan at digit 0
//   an      one-hot digit select, active-high (bit k lights digit k)
//   seg     segment drive, active-high, ordered {dp,g,f,e,d,c,b,a}; dp is 0
//
// Parameters:
//   SCAN_DIV  number of clk cycles each digit stays lit (2..2^20)
//   BLANK_LZ  1 blanks leading zero digits; digit 0 is never blanked

module seg_hex_scanner #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data,
    input  logic        load,
    input  logic        enable,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int unsigned CNT_W    = $clog2(SCAN_DIV);
    localparam int unsigned DIGITS   = 8;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned SEG_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    // Stop elaboration when the divider is outside its legal range.
    if (SCAN_DIV < 2 || SCAN_DIV > (1 << 20)) begin : g_bad_div
        $error("seg_hex_scanner: SCAN_DIV out of range 2..2^20");
    end

    // hex nibble to {dp,g,f,e,d,c,b,a}
    function automatic logic [SEG_W-1:0] hex7(input logic [3:0] nib);
        logic [SEG_W-1:0] s;
        case (nib)
            4'h0:    s = 8'h3F;
            4'h1:    s = 8'h06;
            4'h2:    s = 8'h5B;
            4'h3:    s = 8'h4F;
            4'h4:    s = 8'h66;
            4'h5:    s = 8'h6D;
            4'h6:    s = 8'h7D;
            4'h7:    s = 8'h07;
            4'h8:    s = 8'h7F;
            4'h9:    s = 8'h6F;
            4'hA:    s = 8'h77;
            4'hB:    s = 8'h7C;
            4'hC:    s = 8'h39;
            4'hD:    s = 8'h5E;
            4'hE:    s = 8'h79;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

    logic [31:0]       shadow;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;

    logic              tick;
    logic [4:0]        nib_lsb;
    logic [3:0]        cur_nib;
    logic              blank;
    logic [SEG_W-1:0]  seg_next;
    logic [DIGITS-1:0] an_next;

    // Decode the current digit from the registered shadow word.
    always_comb begin
        tick     = (cnt == CNT_LAST);
        nib_lsb  = {idx, 2'b00};
        cur_nib  = shadow[nib_lsb +: 4];
        // A digit is blank when it and every digit to its left are zero.
        blank    = BLANK_LZ && (idx != '0) && ((shadow >> nib_lsb) == 32'h0);
        seg_next = blank ? '0 : hex7(cur_nib);
        an_next  = DIGITS'(1) << idx;
    end

    // Shadow register. Load does not depend on enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow <= '0;
        end else if (load) begin
            shadow <= data;
        end
    end

    // Prescaler and digit index. Both are held at zero while disabled, so
    // re-enabling starts a full-length slot for digit 0.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= idx + IDX_W'(1);
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Output register. It samples the pre-edge idx and shadow. A load
    // therefore shows on the next edge, and an stays one-hot or zero.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            an  <= '0;
            seg <= '0;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg_hex_scanner.sv
// Directed bench for seg_hex_scanner with SCAN_DIV=4. Two instances share
// the same stimulus: u_lz has BLANK_LZ=1 and u_all has BLANK_LZ=0.

module tb_seg_hex_scanner;

    logic        clk;
    logic        reset;
    logic [31:0] data;
    logic        load;
    logic        enable;
    logic [7:0]  an_lz, seg_lz, an_all, seg_all;

    int total = 0;
    int bad   = 0;

    seg_hex_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) u_lz (
        .clk(clk), .reset(reset), .data(data), .load(load), .enable(enable),
        .an(an_lz), .seg(seg_lz)
    );

    seg_hex_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) u_all (
        .clk(clk), .reset(reset), .data(data), .load(load), .enable(enable),
        .an(an_all), .seg(seg_all)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // n edges with fixed expected an and per-instance seg values.
    task automatic hold(input int n, input logic [7:0] an_e,
                        input logic [7:0] s_lz, input logic [7:0] s_all,
                        input string tag);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s.an_lz[%0d]", tag, i), 32'(an_lz), 32'(an_e));
            chk($sformatf("%s.seg_lz[%0d]", tag, i), 32'(seg_lz), 32'(s_lz));
            chk($sformatf("%s.an_all[%0d]", tag, i), 32'(an_all), 32'(an_e));
            chk($sformatf("%s.seg_all[%0d]", tag, i), 32'(seg_all), 32'(s_all));
            chk($sformatf("%s.onehot0[%0d]", tag, i), 32'($onehot0(an_lz)), 32'(1));
        end
    endtask

    // A full frame from digit 0. Byte k of each table is digit k's segments.
    task automatic run_frame(input logic [63:0] t_lz, input logic [63:0] t_all,
                             input string tag);
        logic [7:0] a;
        for (int k = 0; k < 8; k++) begin
            a = 8'h01 << k;
            hold(4, a, t_lz[8*k +: 8], t_all[8*k +: 8], $sformatf("%s.d%0d", tag, k));
        end
    endtask

    // Load a word while disabled, then enable so the scan starts on digit 0.
    task automatic load_restart(input logic [31:0] w, input string tag);
        enable = 1'b0;
        load   = 1'b1;
        data   = w;
        hold(1, 8'h00, 8'h00, 8'h00, {tag, ".dis"});
        load   = 1'b0;
        enable = 1'b1;
    endtask

    initial begin
        reset  = 1'b1;
        load   = 1'b0;
        enable = 1'b1;
        data   = 32'h0;

        hold(2, 8'h00, 8'h00, 8'h00, "rst");
        reset = 1'b0;

        // 1234ABCD: no leading zeros, so both instances match. Then wrap.
        load_restart(32'h1234ABCD, "w1234");
        run_frame(64'h065B4F66777C395E, 64'h065B4F66777C395E, "w1234");
        hold(1, 8'h01, 8'h5E, 8'h5E, "wrap");

        // 000000A5: digits 2..7 blank only with BLANK_LZ=1.
        load_restart(32'h000000A5, "wa5");
        run_frame(64'h000000000000776D, 64'h3F3F3F3F3F3F776D, "wa5");

        // All zero: only digit 0 shows when blanking.
        load_restart(32'h00000000, "w0");
        run_frame(64'h000000000000003F, 64'h3F3F3F3F3F3F3F3F, "w0");

        // Load in the middle of digit 3. The scan position does not change.
        enable = 1'b0;
        hold(1, 8'h00, 8'h00, 8'h00, "mid.dis");
        enable = 1'b1;
        hold(4, 8'h01, 8'h3F, 8'h3F, "mid.d0");
        hold(4, 8'h02, 8'h00, 8'h3F, "mid.d1");
        hold(4, 8'h04, 8'h00, 8'h3F, "mid.d2");
        hold(2, 8'h08, 8'h00, 8'h3F, "mid.d3a");
        load = 1'b1;
        data = 32'hFFFFFFFF;
        hold(1, 8'h08, 8'h00, 8'h3F, "mid.ldedge");
        load = 1'b0;
        hold(1, 8'h08, 8'h71, 8'h71, "mid.d3new");
        hold(1, 8'h10, 8'h71, 8'h71, "mid.d4");

        // Disable for 10 cycles. On re-enable, digit 0 gets a full slot.
        enable = 1'b0;
        hold(10, 8'h00, 8'h00, 8'h00, "dis");
        enable = 1'b1;
        hold(4, 8'h01, 8'h71, 8'h71, "ren.d0");
        hold(4, 8'h02, 8'h71, 8'h71, "ren.d1");
        hold(4, 8'h04, 8'h71, 8'h71, "ren.d2");
        hold(4, 8'h08, 8'h71, 8'h71, "ren.d3");
        hold(4, 8'h10, 8'h71, 8'h71, "ren.d4");
        hold(2, 8'h20, 8'h71, 8'h71, "ren.d5");

        // Reset during digit 5 with load high. Reset wins over load.
        reset = 1'b1;
        load  = 1'b1;
        data  = 32'h12345678;
        hold(1, 8'h00, 8'h00, 8'h00, "rst5");
        reset = 1'b0;
        load  = 1'b0;
        hold(4, 8'h01, 8'h3F, 8'h3F, "post.d0");
        hold(4, 8'h02, 8'h00, 8'h3F, "post.d1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_hex_scanner.md
# seg_hex_scanner

Display stage that consumes the 32-bit registered word produced by the datapath flip-flop stage and shows it as eight hexadecimal digits on the board's multiplexed 7-segment display. It keeps its own shadow copy of the word, loaded on a strobe. It time-multiplexes the digits using a clock prescaler, with optional leading-zero blanking. All outputs are registered, so the pins are glitch-free.

## Interface

- SCAN_DIV, 100000: clk cycles each digit stays lit. 100 MHz clock gives 1 ms per digit. Legal range is 2..2^20.
- BLANK_LZ, 1: when 1, leading zero digits are blanked. Digit 0 is never blanked.
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- data  input  32  word to display. Nibble k (data[4k+3:4k]) drives digit k; digit 0 is the rightmost.
- load  input  1  when 1 at a rising edge, data is captured into the shadow register.
- enable  input  1  when 0, the display is dark and scanning is held at the start.
- an  output  8  digit select, one-hot, active-high. Bit k lights digit k.
- seg  output  8  segment drive, active-high, ordered {dp,g,f,e,d,c,b,a}. dp is always 0.

## Operation

- Shadow register `shadow[31:0]`:
  - reset clears it to 0.
  - `load=1` captures `data`; otherwise it holds.
  - `load` works regardless of `enable`.
- Prescaler `cnt`:
  - counts 0..SCAN_DIV-1 while `enable=1`.
  - `tick` is asserted when `cnt==SCAN_DIV-1`; on that edge `cnt` wraps to 0.
  - width is ceil(log2(SCAN_DIV)).
- Digit index `idx[2:0]`:
  - advances by 1 on `tick` and wraps from 7 to 0.
  - reset sets it to 0.
- `enable=0`: `cnt` and `idx` are forced to 0 on each edge, and `an` and `seg` are registered to 0.
- Output register, updated every edge with `enable=1`:
  - `an <= 8'b1 << idx`.
  - `seg <= blank(idx) ? 8'h00 : hex7(shadow[4*idx+3 -: 4])`.
- Blanking: `blank(i) = BLANK_LZ && i!=0 && shadow[31:4*i]==0`. With `BLANK_LZ=0`, all eight digits are always shown.
- `hex7` mapping:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
  - 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71

## Timing

- Reset values: `an=8'h00`, `seg=8'h00`, `shadow=0`, `cnt=0`, `idx=0`. Reset has priority over `load` and `enable`.
- After reset is deasserted with `enable=1`, the first edge gives `an=8'h01` and `seg` = digit 0 of `shadow`.
- Each digit stays lit for exactly SCAN_DIV cycles. One full frame is 8*SCAN_DIV cycles.
- Load latency: with `load` high at edge N, `shadow` updates at N. `seg`/`an` reflect the new value from edge N+1, on whichever digit is current. There is no restart of the scan.
- Simultaneous `load` and `tick` at edge N: both take effect. Edge N+1 outputs the new `idx` together with the new `shadow`.
- `enable` 1 to 0 at edge N: outputs are 0 from edge N.
- `enable` 0 to 1 at edge N: edge N produces `an=8'h01`, and digit 0 lasts a full SCAN_DIV cycles starting at N.
- Reset mid-frame: all state returns to reset values at that edge. The partial digit is abandoned.
- `an` is always either 0 or exactly one-hot. It is never multi-hot in any cycle.

## Test plan

All scenarios use SCAN_DIV=4.

- Reset, then `load` 32'h1234ABCD with `enable=1` and BLANK_LZ=1. Required: digits 0..7 show 5E,39,7C,77,66,4F,5B,06, with `an` stepping 01,02,...,80, each for 4 cycles, then wrap to 01.
- `load` 32'h000000A5 with BLANK_LZ=1. Required: digit0 `seg=6D`, digit1 `seg=77`, digits 2..7 `seg=00`. `an` still scans all 8.
- Same word with BLANK_LZ=0. Required: digits 2..7 `seg=3F`.
- `load` 0. Required: digit0 `seg=3F`, all others `seg=00` (BLANK_LZ=1).
- Mid-digit-3, `load` 32'hFFFFFFFF. Required: next edge `an=08`, `seg=71`. Scan position is unchanged and digit 3 completes its 4-cycle slot.
- `enable=0` for 10 cycles, then 1. Required: `an`/`seg`=0 while disabled, then `an=01` on the re-enable edge.
- Assert `reset` during digit 5 with `load=1`. Required: at that edge `an=00`, `seg=00`, `shadow=0`, and the `load` is ignored.
